reg_operand_fetch: RTL and testbench
====================================

// Module: reg_operand_fetch
// PURPOSE
// Operand-fetch stage in front of regbank_v4: drives its read selects sr1/sr2,
// captures rdData1/rdData2 into an output pipeline register and hands operands
// downstream over valid/ready. Keeps a per-register busy scoreboard that stalls
// RAW/WAW hazards. Snoops the regfile write port to bypass same-cycle write data.
// PARAMETERS
// DATA_W   32  operand / write-data width
// ADDR_W   5   register index width; NREGS = 2**ADDR_W (32)
// CNT_W    16  width of stall performance counter
// PORTS
// clk          in   1       clock, all state on rising edge
// rst          in   1       asynchronous reset, active-low (0 = reset)
// in_valid     in   1       upstream has an instruction
// in_ready     out  1       stage accepts this cycle
// in_rs1       in   ADDR_W  source register 1 index
// in_rs2       in   ADDR_W  source register 2 index
// in_rd        in   ADDR_W  destination index (0 = no write)
// sr1          out  ADDR_W  regfile read select 1 (= in_rs1, combinational)
// sr2          out  ADDR_W  regfile read select 2 (= in_rs2, combinational)
// rdData1      in   DATA_W  regfile read data 1 (async read)
// rdData2      in   DATA_W  regfile read data 2 (async read)
// wb_en        in   1       regfile write this cycle (same signals as regfile)
// wb_addr      in   ADDR_W  regfile write index
// wb_data      in   DATA_W  regfile write data
// out_valid    out  1       operands valid downstream
// out_ready    in   1       downstream accepts
// out_op1      out  DATA_W  resolved operand 1
// out_op2      out  DATA_W  resolved operand 2
// out_rd       out  ADDR_W  destination index passed through
// stall_cnt    out  CNT_W   cycles with in_valid=1 and hazard=1, saturating
// BEHAVIOUR
// - Reset (rst=0, immediate): out_valid=0, out_op1/op2=0, out_rd=0,
//   busy[] all 0, stall_cnt=0. in_ready follows from comb logic (1 after reset).
// - wb_hit(r) = wb_en & (wb_addr==r) & (r!=0). wb_en with wb_addr=0 is ignored.
// - busy_eff(r) = busy[r] & (r!=0) & ~wb_hit(r).
// - hazard = busy_eff(in_rs1) | busy_eff(in_rs2) | busy_eff(in_rd).
// - in_ready = (~out_valid | out_ready) & ~hazard. accept = in_valid & in_ready.
// - Operand resolve (comb): rs==0 -> 0; else wb_hit(rs) -> wb_data;
//   else rdDataN. Captured into out_op* on accept; latency 1 cycle.
// - Output reg: on accept load op1/op2/rd, out_valid=1; else if out_ready,
//   out_valid=0 (data held). While out_valid & ~out_ready all out_* stable.
// - Scoreboard per edge: wb_hit(wb_addr) clears busy[wb_addr]; accept with
//   in_rd!=0 sets busy[in_rd]. Same register both: set wins. busy[0] always 0.
// - Full throughput: back-to-back accepts with out_ready=1, no bubbles.
// - stall_cnt: +1 when in_valid & hazard; holds at 2**CNT_W-1.
// - Reset mid-operation: in-flight output dropped, all busy cleared.
// TESTING
// 1 Reset: rst=0 with out_valid=1 -> out_valid=0, stall_cnt=0, in_ready=1.
// 2 rs1=3,rs2=1,rd=5, rdData1=32'hDEADBEEF, rdData2=7 -> next cycle out_valid=1,
//   out_op1=DEADBEEF, out_op2=7, out_rd=5; busy[5]=1.
// 3 RAW: next in_rs1=5 while busy[5] -> in_ready=0, stall_cnt increments;
//   wb_en=1,wb_addr=5,wb_data=32'h1234 -> accepted that cycle, out_op1=1234.
// 4 x0: rs1=0,rd=0, rdData1=FFFFFFFF -> out_op1=0; busy unchanged; wb to 0 no-op.
// 5 Backpressure: out_ready=0 two cycles -> outputs stable, in_ready=0;
//   out_ready=1 -> drains, next instruction accepted same cycle.
// 6 WAW + set-wins: busy[7]=1, in_rd=7 with wb_hit(7) same cycle -> accepted,
//   busy[7] stays 1.

Source files
------------

// File: rtl/reg_operand_fetch_if.sv
// Bus bundle for the operand-fetch stage: upstream issue, regfile read/snoop,
// downstream operand handshake and the stall counter.
interface reg_operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [ADDR_W-1:0] out_rd;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, rdData1, rdData2,
           wb_en, wb_addr, wb_data, out_ready,
    output in_ready, sr1, sr2, out_valid, out_op1, out_op2, out_rd, stall_cnt
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, rdData1, rdData2,
           wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, sr1, sr2, out_valid, out_op1, out_op2, out_rd, stall_cnt
  );
endinterface

// File: rtl/reg_operand_fetch.sv
// Operand-fetch stage: reads the regfile, bypasses same-cycle writeback,
// stalls RAW/WAW hazards via a busy scoreboard, registers operands downstream.
module reg_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_operand_fetch_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0]  busy_q,  busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] op1_q,   op1_d;
  logic [DATA_W-1:0] op2_q,   op2_d;
  logic [ADDR_W-1:0] rd_q,    rd_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              wb_live;
  logic              hazard;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] op1_res, op2_res;

  // A writeback to x0 is discarded by the regfile, so it never bypasses or clears.
  assign wb_live = bus.wb_en && (bus.wb_addr != '0);

  function automatic logic wb_hit(input logic live, input logic [ADDR_W-1:0] wa,
                                  input logic [ADDR_W-1:0] r);
    return live && (wa == r) && (r != '0);
  endfunction

  function automatic logic busy_eff(input logic [NREGS-1:0] busy, input logic live,
                                    input logic [ADDR_W-1:0] wa,
                                    input logic [ADDR_W-1:0] r);
    return busy[r] && (r != '0) && !wb_hit(live, wa, r);
  endfunction

  function automatic logic [DATA_W-1:0] resolve(input logic live,
                                                input logic [ADDR_W-1:0] wa,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [ADDR_W-1:0] rs,
                                                input logic [DATA_W-1:0] rf);
    if (rs == '0)                 return '0;
    else if (wb_hit(live, wa, rs)) return wd;
    else                          return rf;
  endfunction

  assign hazard = busy_eff(busy_q, wb_live, bus.wb_addr, bus.in_rs1) ||
                  busy_eff(busy_q, wb_live, bus.wb_addr, bus.in_rs2) ||
                  busy_eff(busy_q, wb_live, bus.wb_addr, bus.in_rd);

  assign in_ready = (!valid_q || bus.out_ready) && !hazard;
  assign accept   = bus.in_valid && in_ready;
  assign op1_res  = resolve(wb_live, bus.wb_addr, bus.wb_data, bus.in_rs1, bus.rdData1);
  assign op2_res  = resolve(wb_live, bus.wb_addr, bus.wb_data, bus.in_rs2, bus.rdData2);

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    stall_d = stall_q;

    if (accept) begin
      valid_d = 1'b1;
      op1_d   = op1_res;
      op2_d   = op2_res;
      rd_d    = bus.in_rd;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end

    // Clear before set so an issue claiming the register being written back keeps it busy.
    if (wb_live)                        busy_d[bus.wb_addr] = 1'b0;
    if (accept && (bus.in_rd != '0))    busy_d[bus.in_rd]   = 1'b1;
    busy_d[0] = 1'b0;

    if (bus.in_valid && hazard && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset with the rest of the state.
  // NOTE: sequential state uses non-blocking assignments only, keeping edge updates order-independent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
    end
  end

  assign bus.sr1       = bus.in_rs1;
  assign bus.sr2       = bus.in_rs2;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_op1   = op1_q;
  assign bus.out_op2   = op2_q;
  assign bus.out_rd    = rd_q;
  assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed bench for reg_operand_fetch: stimulus pushes expected operands into
// a queue; a negedge monitor pops and compares on each downstream handshake.
module tb_reg_operand_fetch;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  reg_operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  reg_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                       input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d1,
                       input logic [DATA_W-1:0] d2);
    bus.in_valid = 1'b1;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.rdData1  = d1;
    bus.rdData2  = d2;
  endtask

  task automatic wb(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic expect_out(input logic [DATA_W-1:0] o1, input logic [DATA_W-1:0] o2,
                            input logic [ADDR_W-1:0] rd);
    exp_t e;
    e.op1 = o1;
    e.op2 = o2;
    e.rd  = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(bus.out_rd), 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_op1", 64'(bus.out_op1), 64'(e.op1));
        check("out_op2", 64'(bus.out_op2), 64'(e.op2));
        check("out_rd",  64'(bus.out_rd),  64'(e.rd));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.rdData1   = '0;
    bus.rdData2   = '0;
    bus.out_ready = 1'b1;
    wb(1'b0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_op1",   64'(bus.out_op1),   64'd0);
    rst = 1'b1;

    // Basic fetch
    issue(5'd3, 5'd1, 5'd5, 32'hDEADBEEF, 32'd7);
    expect_out(32'hDEADBEEF, 32'd7, 5'd5);
    @(negedge clk);
    check("basic_in_ready", 64'(bus.in_ready), 64'd1);
    check("basic_sr1", 64'(bus.sr1), 64'd3);
    check("basic_sr2", 64'(bus.sr2), 64'd1);
    step();

    // RAW on x5, resolved by a same-cycle writeback bypass
    issue(5'd5, 5'd2, 5'd6, 32'h00000BAD, 32'h22);
    @(negedge clk);
    check("raw_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    @(negedge clk);
    check("raw_stall_1", 64'(bus.stall_cnt), 64'd1);
    step();
    wb(1'b1, 5'd5, 32'h1234);
    expect_out(32'h1234, 32'h22, 5'd6);
    @(negedge clk);
    check("raw_bypass_ready", 64'(bus.in_ready), 64'd1);
    check("raw_stall_2", 64'(bus.stall_cnt), 64'd2);
    step();

    // x0 sources read as zero; writeback to x0 ignored
    issue(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wb(1'b1, 5'd0, 32'h55);
    expect_out(32'd0, 32'd0, 5'd0);
    @(negedge clk);
    check("x0_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // x6 still busy after the x0 instruction
    issue(5'd6, 5'd0, 5'd0, 32'h00066BAD, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("x6_busy", 64'(bus.in_ready), 64'd0);
    step();
    wb(1'b1, 5'd6, 32'h66);
    expect_out(32'h66, 32'd0, 5'd0);
    @(negedge clk);
    check("x6_bypass_ready", 64'(bus.in_ready), 64'd1);
    check("x6_stall_3", 64'(bus.stall_cnt), 64'd3);
    step();

    // Backpressure: outputs hold, no accept, no stall counting
    wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd0, 32'hA1, 32'hA2);
    expect_out(32'hA1, 32'hA2, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_op1", 64'(bus.out_op1), 64'h66);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_ready", 64'(bus.in_ready), 64'd1);
    check("bp_stall_hold", 64'(bus.stall_cnt), 64'd3);
    step();

    // WAW with set-wins on x7
    issue(5'd0, 5'd0, 5'd7, 32'h1, 32'h2);
    expect_out(32'd0, 32'd0, 5'd7);
    @(negedge clk);
    check("waw_first_ready", 64'(bus.in_ready), 64'd1);
    step();
    wb(1'b1, 5'd7, 32'h77);
    expect_out(32'd0, 32'd0, 5'd7);
    @(negedge clk);
    check("waw_hit_ready", 64'(bus.in_ready), 64'd1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("waw_set_wins", 64'(bus.in_ready), 64'd0);
    step();
    wb(1'b1, 5'd7, 32'h78);
    expect_out(32'd0, 32'd0, 5'd7);
    @(negedge clk);
    check("waw_stall_4", 64'(bus.stall_cnt), 64'd4);
    step();

    // Reset while an output is pending
    wb(1'b0, 5'd0, 32'h0);
    issue(5'd0, 5'd0, 5'd9, 32'h0, 32'h0);
    expect_out(32'd0, 32'd0, 5'd9);
    @(negedge clk);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_rd", 64'(bus.out_rd), 64'd9);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    check("midrst_out_rd",    64'(bus.out_rd),    64'd0);
    step();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    issue(5'd9, 5'd0, 5'd0, 32'h99, 32'h0);
    expect_out(32'h99, 32'd0, 5'd0);
    @(negedge clk);
    check("post_rst_x9_free", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
